act_bit_serializer: RTL and testbench
=====================================

Name: act_bit_serializer

Overview:
- Input-side counterpart to the readout activation path: accepts one vector of LANES 8-bit activations from the iobuf side.
- Drives the vector into the analog array one bit-plane per handshake, LSB first, during the chip's inbit state.
- Sits between the iobuf write path and the array word-line/input drivers.
- Reports a weight flag so the downstream accumulator can apply negative MSB weight in signed mode.

Parameters:
LANES, 16, number of parallel activation lanes (one bit per lane per plane)
BITS, 8, activation width; planes per vector
SKIP_ZERO, 0, when 1, all-zero bit-planes are skipped without a handshake

Ports:
CLK  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  activation vector available
in_ready  out  1  block can accept a vector
in_data  in  LANES*BITS  lane i occupies bits [i*BITS +: BITS]
in_signed  in  1  sampled with in_data; 1 = two's-complement activations
bit_valid  out  1  bit_plane is presented to the array
bit_ack  in  1  array has consumed the current plane
bit_plane  out  LANES  bit bit_idx of every lane
bit_idx  out  clog2(BITS)  index of the presented plane
bit_neg  out  1  1 when the plane carries negative weight (signed and bit_idx==BITS-1)
bit_last  out  1  presented plane is the final plane of the vector
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the vector completes

Behaviour:
- Reset: CLK-independent. Forces state IDLE, clears the data register, and drives 0 on bit_valid, bit_plane, bit_idx, bit_neg, bit_last, busy and done.
- in_ready = (state==IDLE), combinational; it therefore reads 1 while reset is held.
- States:
  - IDLE, SEND, SKIP (only when SKIP_ZERO=1), DONE.
- IDLE:
  - in_valid & in_ready at edge k latches in_data and in_signed and sets idx=0.
  - At k+1, enter SEND with plane 0 (or SKIP if SKIP_ZERO and plane 0 is all-zero).
- SEND:
  - bit_valid=1; outputs are held stable until bit_ack is sampled high.
  - On ack with idx<BITS-1: idx++ and the next plane is presented in the following cycle, with no bubble.
  - On ack with idx==BITS-1: go to DONE.
- SKIP:
  - bit_valid=0; idx++ one cycle per consecutive zero plane; no ack is expected.
  - If the skipped plane was BITS-1, go to DONE.
  - In signed mode the MSB plane is never skipped.
- DONE:
  - done=1 for exactly one cycle, in_ready=0, then IDLE.
  - The earliest next accept is the cycle after DONE.
- bit_last = (idx==BITS-1) or, with SKIP_ZERO, all remaining planes are zero.
  - bit_last is meaningful only while bit_valid=1.
- bit_ack while bit_valid=0 is ignored.
- in_valid outside IDLE is ignored; the data is not latched.
- Reset asserted mid-vector abandons the vector: no done pulse, and no further bit_valid until a new accept.
- Latency with SKIP_ZERO=0 and immediate acks: accept → done is BITS+1 cycles (BITS SEND cycles plus the DONE cycle). No plane is ever presented twice or out of order.

Test Plan:
- Unsigned, LANES=16, lane0=0xA5, other lanes 0, ack tied high:
  - Required: bit_plane[0] over idx 0..7 = 1,0,1,0,0,1,0,1.
  - bit_valid high for 8 consecutive cycles starting the cycle after accept.
  - done pulses at accept+9 cycles; bit_neg=0 throughout.
- Signed vector, lane3=0x80:
  - Required: bit_neg=1 and bit_last=1 only at idx 7; bit_plane[3]=1 only at idx 7.
- Backpressure: ack low for 3 cycles on plane 2.
  - Required: bit_plane and bit_idx=2 held stable for 4 cycles; plane 3 appears the cycle after the ack.
- SKIP_ZERO=1, all lanes 0x01, unsigned:
  - Required: one valid plane (idx 0, bit_last=1), then 7 SKIP cycles with bit_valid=0, then done.
- Reset asserted during plane 4:
  - Required: bit_valid and busy drop immediately; no done pulse; in_ready=1.
  - A new vector accepted after release restarts at idx 0.
- in_valid held high through a transfer with changing in_data:
  - Required: only the first value is transmitted.
  - The second vector is accepted exactly one cycle after done.

Source files
------------

// File: rtl/act_bit_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | act_bit_serializer: streams one latched activation vector into the array   |
// | one bit-plane per handshake, LSB first.   Revision: 1.0                    |
// +----------------------------------------------------------------------------+
module act_bit_serializer #(
  parameter int LANES     = 16,
  parameter int BITS      = 8,
  parameter int SKIP_ZERO = 0,
  localparam int c_IDX_W  = (BITS > 1) ? $clog2(BITS) : 1
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*BITS-1:0]    in_data,
  input  logic                     in_signed,
  output logic                     bit_valid,
  input  logic                     bit_ack,
  output logic [LANES-1:0]         bit_plane,
  output logic [c_IDX_W-1:0]       bit_idx,
  output logic                     bit_neg,
  output logic                     bit_last,
  output logic                     busy,
  output logic                     done
);

  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_SKIP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q;
  logic [LANES*BITS-1:0]   data_q;
  logic                    signed_q;
  logic [c_IDX_W-1:0]      idx_q;
  logic                    valid_q;
  logic [LANES-1:0]        plane_q;
  logic                    neg_q;
  logic                    last_q;
  logic                    busy_q;
  logic                    done_q;

  logic [LANES-1:0]        w_in_planes [BITS];
  logic [LANES-1:0]        w_q_planes  [BITS];
  logic [BITS-1:0]         w_in_nz;
  logic [BITS-1:0]         w_q_nz;
  logic [c_IDX_W-1:0]      nxt_idx_d;

  // Transpose lane-major data into bit-plane-major views.
  generate
    for (genvar b = 0; b < BITS; b++) begin : g_plane
      for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_in_planes[b][l] = in_data[l*BITS + b];
        assign w_q_planes[b][l]  = data_q[l*BITS + b];
      end
      assign w_in_nz[b] = |w_in_planes[b];
      assign w_q_nz[b]  = |w_q_planes[b];
    end
  endgenerate

  assign nxt_idx_d = idx_q + c_IDX_W'(1);

  function automatic logic rest_zero(input logic [BITS-1:0] nz, input logic [c_IDX_W-1:0] n);
    rest_zero = (((nz >> n) >> 1) == '0);
  endfunction

  // The signed MSB plane carries the sign weight and must always be presented.
  function automatic logic can_skip(input logic [BITS-1:0] nz, input logic sgn,
                                    input logic [c_IDX_W-1:0] n);
    can_skip = (SKIP_ZERO != 0) && !nz[n] && !(sgn && (n == c_LAST));
  endfunction

  function automatic logic is_last(input logic [BITS-1:0] nz, input logic sgn,
                                   input logic [c_IDX_W-1:0] n);
    is_last = (n == c_LAST) || ((SKIP_ZERO != 0) && !sgn && rest_zero(nz, n));
  endfunction

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      plane_q  <= '0;
      neg_q    <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            signed_q <= in_signed;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            plane_q  <= w_in_planes[0];
            neg_q    <= in_signed && (c_LAST == '0);
            last_q   <= is_last(w_in_nz, in_signed, '0);
            if (can_skip(w_in_nz, in_signed, '0)) begin
              state_q <= S_SKIP;
              valid_q <= 1'b0;
            end else begin
              state_q <= S_SEND;
              valid_q <= 1'b1;
            end
          end
        end
        S_SEND, S_SKIP: begin
          if (bit_ack || (state_q == S_SKIP)) begin
            if (idx_q == c_LAST) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              plane_q <= '0;
              neg_q   <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= nxt_idx_d;
              plane_q <= w_q_planes[nxt_idx_d];
              neg_q   <= signed_q && (nxt_idx_d == c_LAST);
              last_q  <= is_last(w_q_nz, signed_q, nxt_idx_d);
              if (can_skip(w_q_nz, signed_q, nxt_idx_d)) begin
                state_q <= S_SKIP;
                valid_q <= 1'b0;
              end else begin
                state_q <= S_SEND;
                valid_q <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          idx_q   <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign bit_valid = valid_q;
  assign bit_plane = plane_q;
  assign bit_idx   = idx_q;
  assign bit_neg   = neg_q;
  assign bit_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_act_bit_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_act_bit_serializer: directed bench for act_bit_serializer (plain and    |
// | zero-skipping instances).   Revision: 1.0                                  |
// +----------------------------------------------------------------------------+
module tb_act_bit_serializer;

  logic         CLK = 1'b0;
  logic         rst = 1'b1;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_signed = 1'b0;
  logic         bit_valid;
  logic         bit_ack = 1'b1;
  logic [15:0]  bit_plane;
  logic [2:0]   bit_idx;
  logic         bit_neg;
  logic         bit_last;
  logic         busy;
  logic         done;

  logic         v1 = 1'b0;
  logic         r1;
  logic [127:0] d1 = '0;
  logic         s1 = 1'b0;
  logic         bv1;
  logic         ack1 = 1'b1;
  logic [15:0]  pl1;
  logic [2:0]   idx1;
  logic         neg1;
  logic         last1;
  logic         busy1;
  logic         done1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  act_bit_serializer #(.LANES(16), .BITS(8), .SKIP_ZERO(0)) u_dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_signed(in_signed), .bit_valid(bit_valid),
    .bit_ack(bit_ack), .bit_plane(bit_plane), .bit_idx(bit_idx),
    .bit_neg(bit_neg), .bit_last(bit_last), .busy(busy), .done(done)
  );

  act_bit_serializer #(.LANES(16), .BITS(8), .SKIP_ZERO(1)) u_dut_skip (
    .CLK(CLK), .rst(rst), .in_valid(v1), .in_ready(r1),
    .in_data(d1), .in_signed(s1), .bit_valid(bv1),
    .bit_ack(ack1), .bit_plane(pl1), .bit_idx(idx1),
    .bit_neg(neg1), .bit_last(last1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Single-lane vector through the plain instance with ack held high.
  task automatic run_vec(input string tag, input logic [127:0] d, input logic s,
                         input int lane, input logic [7:0] expb);
    logic [15:0] exp_plane;
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = s;
    tick();
    in_valid  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_plane = 16'(((expb >> i) & 8'd1)) << lane;
      chk({tag, " valid"}, 64'(bit_valid), 64'd1);
      chk({tag, " idx"},   64'(bit_idx),   64'(i));
      chk({tag, " plane"}, 64'(bit_plane), 64'(exp_plane));
      chk({tag, " neg"},   64'(bit_neg),   64'(s && (i == 7)));
      chk({tag, " last"},  64'(bit_last),  64'(i == 7));
      chk({tag, " done_early"}, 64'(done), 64'd0);
      tick();
    end
    chk({tag, " done"},        64'(done),      64'd1);
    chk({tag, " valid_off"},   64'(bit_valid), 64'd0);
    chk({tag, " ready_done"},  64'(in_ready),  64'd0);
    tick();
    chk({tag, " done_pulse"},  64'(done),      64'd0);
    chk({tag, " ready_after"}, 64'(in_ready),  64'd1);
    chk({tag, " busy_after"},  64'(busy),      64'd0);
  endtask

  initial begin
    // Reset state while rst is held across a clock edge.
    tick();
    chk("rst valid", 64'(bit_valid), 64'd0);
    chk("rst busy",  64'(busy),      64'd0);
    chk("rst done",  64'(done),      64'd0);
    chk("rst ready", 64'(in_ready),  64'd1);
    chk("rst idx",   64'(bit_idx),   64'd0);
    chk("rst plane", 64'(bit_plane), 64'd0);
    chk("rst valid1", 64'(bv1),      64'd0);
    rst = 1'b0;
    tick();

    // Unsigned lane0 = 0xA5 -> planes 1,0,1,0,0,1,0,1.
    run_vec("a5", 128'h00A5, 1'b0, 0, 8'b1010_0101);

    // Signed lane3 = 0x80: only the MSB plane is set and negative.
    run_vec("s80", 128'h8000_0000, 1'b1, 3, 8'b1000_0000);

    // Backpressure on plane 2, lane1 = 0x3C.
    in_valid = 1'b1;
    in_data  = 128'h3C00;
    in_signed = 1'b0;
    bit_ack  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    bit_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("bp idx",   64'(bit_idx),   64'd2);
      chk("bp plane", 64'(bit_plane), 64'h0002);
      chk("bp valid", 64'(bit_valid), 64'd1);
      if (k == 3) bit_ack = 1'b1;
      tick();
    end
    chk("bp next idx",   64'(bit_idx),   64'd3);
    chk("bp next plane", 64'(bit_plane), 64'h0002);
    for (int k = 0; k < 4; k++) tick();
    chk("bp idx7",   64'(bit_idx),   64'd7);
    chk("bp plane7", 64'(bit_plane), 64'h0000);
    tick();
    chk("bp done", 64'(done), 64'd1);
    tick();

    // Reset during plane 4 abandons the vector.
    in_valid = 1'b1;
    in_data  = 128'h00FF;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("mid idx4", 64'(bit_idx), 64'd4);
    rst = 1'b1;
    #1;
    chk("mid rst valid", 64'(bit_valid), 64'd0);
    chk("mid rst busy",  64'(busy),      64'd0);
    chk("mid rst ready", 64'(in_ready),  64'd1);
    chk("mid rst done",  64'(done),      64'd0);
    @(posedge CLK);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post rst done",  64'(done),      64'd0);
      chk("post rst valid", 64'(bit_valid), 64'd0);
      tick();
    end
    run_vec("restart", 128'h000F, 1'b0, 0, 8'b0000_1111);

    // in_valid held high with changing data: first vector only, second after done.
    in_valid = 1'b1;
    in_data  = 128'h0001;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("hold planeA", 64'(bit_plane), (i == 0) ? 64'h1 : 64'h0);
      chk("hold ready",  64'(in_ready),  64'd0);
      in_data = {112'd0, 8'(i + 1), 8'h80};
      tick();
    end
    in_data = 128'h0080;
    chk("hold done",       64'(done),     64'd1);
    chk("hold ready_done", 64'(in_ready), 64'd0);
    tick();
    chk("hold ready_idle", 64'(in_ready),  64'd1);
    chk("hold idle valid", 64'(bit_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      chk("hold B valid", 64'(bit_valid), 64'd1);
      chk("hold B idx",   64'(bit_idx),   64'(i));
      chk("hold planeB",  64'(bit_plane), (i == 7) ? 64'h1 : 64'h0);
    end
    tick();
    chk("hold B done", 64'(done), 64'd1);
    tick();

    // Zero skipping, all lanes 0x01 unsigned.
    d1 = {16{8'h01}};
    s1 = 1'b0;
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("sk valid0", 64'(bv1),   64'd1);
    chk("sk idx0",   64'(idx1),  64'd0);
    chk("sk last0",  64'(last1), 64'd1);
    chk("sk plane0", 64'(pl1),   64'hFFFF);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("sk skip valid", 64'(bv1),   64'd0);
      chk("sk skip idx",   64'(idx1),  64'(i));
      chk("sk skip busy",  64'(busy1), 64'd1);
      chk("sk skip done",  64'(done1), 64'd0);
    end
    tick();
    chk("sk done",  64'(done1), 64'd1);
    chk("sk valid", 64'(bv1),   64'd0);
    tick();
    chk("sk ready", 64'(r1), 64'd1);

    // Zero skipping, signed lane0 = 0x01: MSB plane still presented.
    d1 = 128'h0001;
    s1 = 1'b1;
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("ss valid0", 64'(bv1),   64'd1);
    chk("ss last0",  64'(last1), 64'd0);
    chk("ss plane0", 64'(pl1),   64'h0001);
    chk("ss neg0",   64'(neg1),  64'd0);
    for (int i = 1; i < 7; i++) begin
      tick();
      chk("ss skip valid", 64'(bv1),  64'd0);
      chk("ss skip idx",   64'(idx1), 64'(i));
    end
    tick();
    chk("ss msb valid", 64'(bv1),   64'd1);
    chk("ss msb idx",   64'(idx1),  64'd7);
    chk("ss msb neg",   64'(neg1),  64'd1);
    chk("ss msb last",  64'(last1), 64'd1);
    chk("ss msb plane", 64'(pl1),   64'h0000);
    tick();
    chk("ss done", 64'(done1), 64'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
